// File: rtl/sha2_pkg.sv
// SHA-2 shared definitions: FSM state, round constants, initial hash values
// and the sigma/Sigma/Ch/Maj helpers used by the round and the schedule.
package sha2_pkg;

    typedef enum logic [1:0] {ST_LOAD, ST_COMPRESS, ST_UPDATE} sha2_state_e;

    typedef logic [31:0] sha2_vars_t [8];

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam sha2_vars_t SHA256_IV = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam sha2_vars_t SHA224_IV = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 compression round: working vars a..h plus W and K
// produce the next a..h. Chained UNROLL times by the core.
module sha2_round
    import sha2_pkg::*;
(
    input  sha2_vars_t  v_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output sha2_vars_t  v_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1     = v_i[7] + big_sigma1(v_i[4]) + ch(v_i[4], v_i[5], v_i[6]) + k_i + w_i;
        t2     = big_sigma0(v_i[0]) + maj(v_i[0], v_i[1], v_i[2]);
        v_o[0] = t1 + t2;
        v_o[1] = v_i[0];
        v_o[2] = v_i[1];
        v_o[3] = v_i[2];
        v_o[4] = v_i[3] + t1;
        v_o[5] = v_i[4];
        v_o[6] = v_i[5];
        v_o[7] = v_i[6];
    end

endmodule

// File: rtl/sha2_core_p.sv
// SHA-256/SHA-224 compression engine, UNROLL rounds per cycle, chaining value
// accumulated across blocks until init. SHA2_SHA224_EN enables the SHA-224 mode.
module sha2_core_p
    import sha2_pkg::*;
#(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         init,
    input  logic         mode224,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [255:0] hash,
    output logic         hash_valid,
    output logic         busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
        $error("sha2_core_p: UNROLL must be 1, 2, 4 or 8");
    end

    sha2_state_e state_q;
    logic [3:0]  cnt_q;
    logic [5:0]  rnd_q;
    logic        blk_q;
    logic [31:0] w_q [16];
    sha2_vars_t  h_q;
    sha2_vars_t  wv_q;
    logic [31:0] wext [16 + UNROLL];
    sha2_vars_t  chain [UNROLL + 1];

`ifdef SHA2_SHA224_EN
    logic        mode_q;
`else
    logic        unused_mode224;
    assign unused_mode224 = mode224;
`endif

    // Schedule words beyond index 15 feed on each other when UNROLL > 2.
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) wext[i] = w_q[i];
        for (int unsigned j = 0; j < UNROLL; j++)
            wext[16 + j] = small_sigma1(wext[14 + j]) + wext[9 + j]
                         + small_sigma0(wext[1 + j]) + wext[j];
    end

    assign chain[0] = wv_q;

    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
        logic [5:0] kidx;
        assign kidx = rnd_q + 6'(gi);
        sha2_round u_round (
            .v_i (chain[gi]),
            .w_i (wext[gi]),
            .k_i (K[kidx]),
            .v_o (chain[gi + 1])
        );
    end

    assign s_ready    = (state_q == ST_LOAD) && !init;
    assign hash_valid = (state_q == ST_LOAD) && (cnt_q == 4'd0) && blk_q;
    assign busy       = (state_q != ST_LOAD);

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) hash[255 - 32 * i -: 32] = h_q[i];
`ifdef SHA2_SHA224_EN
        if (mode_q) hash[31:0] = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            rnd_q   <= '0;
            blk_q   <= 1'b0;
            h_q     <= SHA256_IV;
`ifdef SHA2_SHA224_EN
            mode_q  <= 1'b0;
`endif
        end else if (init) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            blk_q   <= 1'b0;
`ifdef SHA2_SHA224_EN
            mode_q  <= mode224;
            if (mode224) h_q <= SHA224_IV;
            else         h_q <= SHA256_IV;
`else
            h_q     <= SHA256_IV;
`endif
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (s_valid) begin
                        for (int unsigned i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
                        w_q[15] <= s_data;
                        cnt_q   <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            wv_q    <= h_q;
                            rnd_q   <= '0;
                            state_q <= ST_COMPRESS;
                        end
                    end
                end
                ST_COMPRESS: begin
                    wv_q <= chain[UNROLL];
                    for (int unsigned i = 0; i < 16; i++) w_q[i] <= wext[i + UNROLL];
                    rnd_q <= rnd_q + 6'(UNROLL);
                    if (rnd_q == 6'(64 - UNROLL)) state_q <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    for (int unsigned i = 0; i < 8; i++) h_q[i] <= h_q[i] + wv_q[i];
                    blk_q   <= 1'b1;
                    state_q <= ST_LOAD;
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_core_p.sv
// Directed-vector bench: four cores (UNROLL 1/2/4/8) share one input stream and
// are checked against known SHA-2 digests, latencies, init and reset behaviour.
module tb_sha2_core_p;

    localparam logic [255:0] IV256   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224Z  = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_00000000;
    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] D_224   = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         init = 1'b0;
    logic         mode224 = 1'b0;
    logic         s_valid = 1'b0;
    logic [31:0]  s_data = '0;
    logic [3:0]   rdy;
    logic [3:0]   hv;
    logic [3:0]   bsy;
    logic [255:0] hsh [4];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] blk_abc   [16] = '{32'h61626380, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000018};
    logic [31:0] blk_empty [16] = '{32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] blk_two1  [16] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    logic [31:0] blk_two2  [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000001c0};

    always #5 clk = ~clk;

    sha2_core_p #(.UNROLL(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .init(init), .mode224(mode224), .s_data(s_data),
        .s_valid(s_valid), .s_ready(rdy[0]), .hash(hsh[0]), .hash_valid(hv[0]), .busy(bsy[0]));
    sha2_core_p #(.UNROLL(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .init(init), .mode224(mode224), .s_data(s_data),
        .s_valid(s_valid), .s_ready(rdy[1]), .hash(hsh[1]), .hash_valid(hv[1]), .busy(bsy[1]));
    sha2_core_p #(.UNROLL(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .init(init), .mode224(mode224), .s_data(s_data),
        .s_valid(s_valid), .s_ready(rdy[2]), .hash(hsh[2]), .hash_valid(hv[2]), .busy(bsy[2]));
    sha2_core_p #(.UNROLL(8)) u_dut8 (
        .clk(clk), .resetn(resetn), .init(init), .mode224(mode224), .s_data(s_data),
        .s_valid(s_valid), .s_ready(rdy[3]), .hash(hsh[3]), .hash_valid(hv[3]), .busy(bsy[3]));

    task automatic check_vec(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_init(input logic m);
        init = 1'b1;
        mode224 = m;
        tick();
        init = 1'b0;
        mode224 = 1'b0;
    endtask

    // All four cores must be in LOAD before words go out, so they stay in lockstep.
    task automatic send_words(input logic [31:0] w [16], input int unsigned n, input bit gaps);
        int unsigned guard = 0;
        while (rdy != 4'hF && guard < 200) begin
            tick();
            guard++;
        end
        if (rdy != 4'hF) check_vec("ready_wait", {252'b0, rdy}, 256'hF);
        for (int unsigned i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            s_valid = 1'b1;
            s_data  = w[i];
            tick();
            s_valid = 1'b0;
            s_data  = 'x;
            if (i == 0) check_vec("hv_drop", {255'b0, hv[0]}, '0);
        end
    endtask

    // Latency counts the edge accepting the 16th word as 1.
    task automatic wait_digest(input string tag, input logic [255:0] exp, input bit chk_hash);
        int unsigned lat [4];
        int unsigned c = 1;
        lat = '{default: 0};
        while (c < 80 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0 || lat[3] == 0)) begin
            tick();
            c++;
            for (int d = 0; d < 4; d++)
                if (hv[d] && lat[d] == 0) lat[d] = c;
        end
        for (int d = 0; d < 4; d++) begin
            if (chk_hash) check_vec($sformatf("%s_u%0d_hash", tag, 1 << d), hsh[d], exp);
            check_vec($sformatf("%s_u%0d_lat", tag, 1 << d), 256'(lat[d]), 256'(64 / (1 << d) + 2));
        end
    endtask

    initial begin
        tick();
        tick();
        for (int d = 0; d < 4; d++) begin
            check_vec($sformatf("rst_hash_u%0d", 1 << d), hsh[d], IV256);
        end
        check_vec("rst_ready", {252'b0, rdy}, 256'hF);
        check_vec("rst_hv",    {252'b0, hv},  '0);
        check_vec("rst_busy",  {252'b0, bsy}, '0);
        resetn = 1'b1;
        tick();

        send_words(blk_abc, 16, 1'b0);
        wait_digest("abc", D_ABC, 1'b1);

        pulse_init(1'b0);
        check_vec("init_hash", hsh[0], IV256);
        check_vec("init_hv", {252'b0, hv}, '0);
        send_words(blk_empty, 16, 1'b0);
        wait_digest("empty", D_EMPTY, 1'b1);

        pulse_init(1'b0);
        send_words(blk_two1, 16, 1'b1);
        wait_digest("two_b1", '0, 1'b0);
        send_words(blk_two2, 16, 1'b1);
        wait_digest("two_b2", D_TWO, 1'b1);

        pulse_init(1'b1);
`ifdef SHA2_SHA224_EN
        check_vec("iv224", hsh[0], IV224Z);
        send_words(blk_abc, 16, 1'b0);
        wait_digest("abc224", D_224, 1'b1);
`else
        check_vec("iv_m224_ignored", hsh[0], IV256);
        send_words(blk_abc, 16, 1'b0);
        wait_digest("abc_m224_ignored", D_ABC, 1'b1);
`endif

        pulse_init(1'b0);
        send_words(blk_abc, 16, 1'b0);
        repeat (20) tick();
        check_vec("mid_busy", {255'b0, bsy[0]}, 256'h1);
        init = 1'b1;
        s_valid = 1'b1;
        s_data = 32'h61626380;
        #1;
        check_vec("init_cmp_ready", {252'b0, rdy}, '0);
        tick();
        init = 1'b0;
        s_valid = 1'b0;
        check_vec("abort_hash", hsh[0], IV256);
        check_vec("abort_hv", {252'b0, hv}, '0);
        check_vec("abort_busy", {252'b0, bsy}, '0);

        send_words(blk_abc, 5, 1'b0);
        init = 1'b1;
        s_valid = 1'b1;
        s_data = 32'hdeadbeef;
        #1;
        check_vec("init_load_ready", {252'b0, rdy}, '0);
        tick();
        init = 1'b0;
        s_valid = 1'b0;
        send_words(blk_abc, 16, 1'b0);
        wait_digest("abc_after_init", D_ABC, 1'b1);

        send_words(blk_abc, 7, 1'b0);
        resetn = 1'b0;
        tick();
        check_vec("mid_rst_hash", hsh[0], IV256);
        check_vec("mid_rst_ready", {252'b0, rdy}, 256'hF);
        check_vec("mid_rst_hv", {252'b0, hv}, '0);
        check_vec("mid_rst_busy", {252'b0, bsy}, '0);
        resetn = 1'b1;
        tick();
        send_words(blk_abc, 16, 1'b0);
        wait_digest("abc_after_rst", D_ABC, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
